sorted_drain: RTL and testbench
===============================

// Module: sorted_drain
// PURPOSE
//  Read-side consumer of the ping-pong buffer written by the final merge stage.
//  On ap_start it reads the N sorted words through one registered-read memory port.
//  It streams them out over a valid/ready interface, tags the last word and checks
//  the sort order (signed, non-decreasing). It is the reader end of the buffer
//  interface: address0, ce0, q0, with 1-cycle read latency.
// PARAMETERS
//  N   16  words per block (power of 2, >=2)
//  DW  32  data width
//  AW  4   address width, log2(N)
// PORTS
//  ap_clk        in   1   clock, rising edge
//  ap_rst_n      in   1   asynchronous active-low reset
//  ap_start      in   1   start request
//  ap_done       out  1   block finished; held until ap_continue
//  ap_continue   in   1   clears done, allows next start
//  ap_idle       out  1   idle and no start pending
//  ap_ready      out  1   1-cycle pulse when the block is accepted as finished
//  buf_address0  out  AW  read address
//  buf_ce0       out  1   read enable; q0 is valid the cycle after
//  buf_q0        in   DW  read data
//  out_data      out  DW  stream data
//  out_valid     out  1   stream valid
//  out_ready     in   1   stream ready (backpressure)
//  out_last      out  1   with out_valid: this is word N-1
//  sorted_ok     out  1   1 = every emitted pair so far is non-decreasing
// BEHAVIOUR
//  Reset (async): FSM=IDLE, all counters 0, 2-deep FIFO empty.
//   Outputs at reset: ap_done=0, ap_ready=0, buf_ce0=0, buf_address0=0,
//   out_valid=0, out_last=0, out_data=0, sorted_ok=1.
//   Reset asserted mid-block aborts the block; nothing is emitted after release.
//  FSM states:
//   IDLE->RUN when ap_start=1. Clear rd_ptr, wr_cnt, out_cnt; set sorted_ok=1.
//   RUN->DONE on the cycle the word with out_cnt==N-1 is handshaken.
//   DONE->IDLE when ap_continue=1.
//  Outputs by state:
//   ap_idle = IDLE & ~ap_start.
//   ap_done = 1 throughout DONE.
//   ap_ready pulses for 1 cycle on the first DONE cycle.
//  Read issue (RUN only): buf_ce0=1 and buf_address0=rd_ptr when rd_ptr<N and
//   (fifo_count + inflight - pop) < 2. Here pop = out_valid & out_ready and
//   inflight = a read issued in the previous cycle. rd_ptr increments per issue.
//  Capture: the cycle after an issue, buf_q0 is pushed into the FIFO. It never
//   overflows, because of the issue rule.
//  Stream: out_valid = FIFO non-empty and out_data = FIFO head.
//   The head is held stable while out_valid & ~out_ready.
//   out_last = out_valid & (out_cnt==N-1).
//  Order check: on each handshake with out_cnt>0, if
//   $signed(out_data) < $signed(prev), sorted_ok is cleared. It stays 0 until
//   the next start. prev is updated on every handshake. Equal words are legal.
//  Counters: rd_ptr and out_cnt are AW+1 bits wide so that N is representable;
//   no wrap inside a block.
//  Latency with out_ready=1 and start accepted at cycle 0:
//   first read in cycle 1; first out_valid in cycle 3;
//   words 0..N-1 in cycles 3..N+2; ap_done from cycle N+3.
//   Throughput is 1 word/cycle.
//  Simultaneous push and pop: both take effect and the count is unchanged.
//  ap_start in RUN or DONE is ignored.
// TESTING
//  T1 buffer = 0..15, out_ready=1: 16 words in cycles 3..18, out_last at word 15,
//     sorted_ok=1, ap_done at 19, ap_ready pulse once.
//  T2 same data, out_ready toggling 1,0: order is preserved, no drops or duplicates,
//     out_data is stable while stalled, buf_ce0 never issues a 3rd outstanding read.
//  T3 buffer with word 7=100, word 8=-5: the stream is unchanged;
//     sorted_ok falls to 0 after the word-8 handshake and stays 0.
//  T4 all words = 32'h8000_0000 (equal, negative): sorted_ok stays 1.
//  T5 ap_continue held 0 for 10 cycles after done: ap_done stays 1; a start pulse
//     is ignored; after continue, a new start re-runs with sorted_ok reset to 1.
//  T6 ap_rst_n pulsed low at word 5: all outputs take reset values immediately;
//     IDLE after release, ap_idle=1.

Source files
------------

// File: rtl/sorted_drain.sv
// Read-side consumer of the final merge-stage ping-pong buffer: reads N words through a
// 1-cycle-latency port, streams them over valid/ready, tags the last word and checks order.
module sorted_drain #(
  parameter int N  = 16,
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          ap_start,
  output logic          ap_done,
  input  logic          ap_continue,
  output logic          ap_idle,
  output logic          ap_ready,
  output logic [AW-1:0] buf_address0,
  output logic          buf_ce0,
  input  logic [DW-1:0] buf_q0,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          sorted_ok
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [AW:0] N_W    = (AW + 1)'(N);
  localparam logic [AW:0] LAST_W = N_W - 1'b1;

  state_t          r_state;
  logic            r_done;
  logic            r_ready;
  logic [AW:0]     r_rd_ptr;
  logic [AW:0]     r_out_cnt;
  logic            r_inflight;
  logic [DW-1:0]   r_fifo [2];
  logic            r_head;
  logic            r_tail;
  logic [1:0]      r_count;
  logic [DW-1:0]   r_prev;
  logic            r_sorted_ok;

  logic            w_start_acc;
  logic            w_pop;
  logic            w_push;
  logic [2:0]      w_occ;
  logic            w_issue;
  logic            w_last_hs;

  assign w_start_acc = (r_state == S_IDLE) && ap_start;
  assign w_pop       = out_valid && out_ready;
  assign w_push      = r_inflight;
  // Occupancy after this cycle's pop, counting the read whose data lands next cycle.
  assign w_occ       = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue     = (r_state == S_RUN) && (r_rd_ptr < N_W) && (w_occ < 3'd2);
  assign w_last_hs   = w_pop && (r_out_cnt == LAST_W);

  assign buf_ce0      = w_issue;
  assign buf_address0 = w_issue ? r_rd_ptr[AW-1:0] : '0;
  assign out_valid    = (r_count != 2'd0);
  assign out_data     = r_fifo[r_head];
  assign out_last     = out_valid && (r_out_cnt == LAST_W);
  assign sorted_ok    = r_sorted_ok;
  assign ap_done      = r_done;
  assign ap_ready     = r_ready;
  assign ap_idle      = (r_state == S_IDLE) && !ap_start;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: if (ap_start) r_state <= S_RUN;
        S_RUN: begin
          if (w_last_hs) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        S_DONE: begin
          if (ap_continue) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the two FIFO entries are reset because the head entry is visible on
  // out_data even when empty, and it must read as zero out of reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rd_ptr    <= '0;
      r_out_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_count     <= 2'd0;
      r_prev      <= '0;
      r_sorted_ok <= 1'b1;
    end else if (w_start_acc) begin
      r_rd_ptr    <= '0;
      r_out_cnt   <= '0;
      r_inflight  <= 1'b0;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_count     <= 2'd0;
      r_sorted_ok <= 1'b1;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push) begin
        r_fifo[r_tail] <= buf_q0;
        r_tail         <= ~r_tail;
      end
      if (w_pop) begin
        r_head    <= ~r_head;
        r_out_cnt <= r_out_cnt + 1'b1;
        r_prev    <= out_data;
        if ((r_out_cnt != '0) && ($signed(out_data) < $signed(r_prev)))
          r_sorted_ok <= 1'b0;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_sorted_drain.sv
// Randomized scoreboard bench for sorted_drain: a buffer model answers reads, a monitor
// compares every presented word against the expected stream derived from buffer contents.
module tb_sorted_drain;
  localparam int N  = 16;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          ap_start;
  logic          ap_done;
  logic          ap_continue;
  logic          ap_idle;
  logic          ap_ready;
  logic [AW-1:0] buf_address0;
  logic          buf_ce0;
  logic [DW-1:0] buf_q0 = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          sorted_ok;

  sorted_drain #(.N(N), .DW(DW), .AW(AW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
    .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .buf_address0(buf_address0), .buf_ce0(buf_ce0), .buf_q0(buf_q0),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .sorted_ok(sorted_ok)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_bad    = 0;
  int cyc      = 0;
  always @(posedge ap_clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Buffer model: registered read, data valid the cycle after ce0.
  int mem [N];
  always @(posedge ap_clk) if (buf_ce0) buf_q0 <= mem[buf_address0];

  // Backpressure: 0 = always ready, 1 = toggle 1,0,1,0..., 2 = random.
  int ready_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge ap_clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    int            idx;
  } exp_t;
  exp_t sb[$];

  int            hs_cyc [N];
  int            ready_pulses = 0;
  int            issued = 0;
  int            popped = 0;
  bit            model_ok = 1'b1;
  logic [DW-1:0] model_prev = '0;
  bit            stalled = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (ap_ready) ready_pulses++;
      if (buf_ce0) issued++;
      if (out_valid && out_ready) popped++;
      if (buf_ce0) check("outstanding_reads_le_2", 64'(issued - popped <= 2), 64'd1);
      if (stalled) begin
        check("stall_valid_held", out_valid, 1'b1);
        check("stall_data_held", out_data, stall_data);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          exp_t e;
          e = sb[0];
          check("sorted_ok_stream", sorted_ok, (e.idx == 0) ? 1'b1 : model_ok);
          check("out_last", out_last, e.last);
          if (out_ready) begin
            check("out_data", out_data, e.d);
            void'(sb.pop_front());
            hs_cyc[e.idx] = cyc;
            if (e.idx == 0) model_ok = 1'b1;
            else if ($signed(e.d) < $signed(model_prev)) model_ok = 1'b0;
            model_prev = e.d;
          end
        end
      end
      stalled    = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  function automatic bit ref_sorted();
    for (int i = 1; i < N; i++) if (mem[i] < mem[i-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fill_sorted_random();
    int q[$];
    for (int i = 0; i < N; i++) q.push_back(int'($urandom));
    q.sort();
    for (int i = 0; i < N; i++) mem[i] = q[i];
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ap_done"}, ap_done, 1'b0);
    check({tag, "_ap_ready"}, ap_ready, 1'b0);
    check({tag, "_buf_ce0"}, buf_ce0, 1'b0);
    check({tag, "_buf_address0"}, buf_address0, '0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_last"}, out_last, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_sorted_ok"}, sorted_ok, 1'b1);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the next one.
  task automatic start_block(output int t0);
    for (int i = 0; i < N; i++) sb.push_back('{d: mem[i], last: (i == N-1), idx: i});
    ap_start = 1'b1;
    t0 = cyc;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
  endtask

  task automatic wait_done(output int dc, output bit got);
    got = 1'b0;
    dc  = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge ap_clk);
      if (ap_done) begin
        dc  = cyc;
        got = 1'b1;
        return;
      end
    end
    check("done_within_budget", ap_done, 1'b1);
  endtask

  task automatic pulse_continue();
    @(posedge ap_clk); #1;
    ap_continue = 1'b1;
    @(posedge ap_clk); #1;
    ap_continue = 1'b0;
    @(negedge ap_clk);
    check("done_cleared", ap_done, 1'b0);
    check("idle_after_continue", ap_idle, 1'b1);
  endtask

  task automatic run_block(input int mode, input bit timing, input bit hold_cont);
    int t0, dc;
    bit got;
    ready_mode   = mode;
    ready_pulses = 0;
    if (mode == 0) out_ready = 1'b1;
    start_block(t0);
    @(negedge ap_clk);
    check("first_read_ce0", buf_ce0, 1'b1);
    check("first_read_addr", buf_address0, '0);
    check("sorted_ok_after_start", sorted_ok, 1'b1);
    check("not_idle_in_run", ap_idle, 1'b0);
    wait_done(dc, got);
    if (got) begin
      if (timing) begin
        check("word0_cycle", 64'(hs_cyc[0] - t0), 64'd3);
        check("wordlast_cycle", 64'(hs_cyc[N-1] - t0), 64'(N + 2));
        check("done_cycle", 64'(dc - t0), 64'(N + 3));
      end
      check("sorted_ok_final", sorted_ok, ref_sorted());
      check("all_words_drained", 64'(sb.size()), 64'd0);
      @(negedge ap_clk);
      check("ap_ready_once", 64'(ready_pulses), 64'd1);
      check("ap_ready_dropped", ap_ready, 1'b0);
      check("done_held", ap_done, 1'b1);
    end
    if (!hold_cont) pulse_continue();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    ap_rst_n    = 1'b0;
    ap_start    = 1'b0;
    ap_continue = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = i;
    repeat (3) @(posedge ap_clk);
    #1;
    check_reset_outputs("reset");
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check("idle_after_reset", ap_idle, 1'b1);
    @(posedge ap_clk); #1;

    // T1: ascending data, full throughput with latency checks.
    run_block(0, 1'b1, 1'b0);

    // T2: toggling backpressure.
    run_block(1, 1'b0, 1'b0);

    // T3: one descent between words 7 and 8, held until continue for T5.
    for (int i = 0; i < N; i++) mem[i] = i;
    mem[7] = 100;
    mem[8] = -5;
    run_block(0, 1'b0, 1'b1);

    // T5: done held while continue stays low; a start pulse there is ignored.
    for (int k = 0; k < 10; k++) begin
      @(posedge ap_clk); #1;
      ap_start = (k == 4);
      @(negedge ap_clk);
      check("done_held_no_continue", ap_done, 1'b1);
      check("no_read_in_done", buf_ce0, 1'b0);
      check("sorted_ok_still_low", sorted_ok, 1'b0);
    end
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    pulse_continue();
    @(posedge ap_clk); #1;

    // T4: equal negative words, then the re-run after continue.
    for (int i = 0; i < N; i++) mem[i] = int'(32'h8000_0000);
    run_block(2, 1'b0, 1'b0);

    fill_sorted_random();
    run_block(2, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) mem[i] = int'($urandom);
    run_block(2, 1'b0, 1'b0);

    // T6: asynchronous reset while word 5 is on the stream.
    fill_sorted_random();
    ready_mode = 0;
    out_ready  = 1'b1;
    start_block(t0);
    while (cyc < t0 + 8) @(negedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    issued  = 0;
    popped  = 0;
    stalled = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge ap_clk);
      check("idle_after_abort", ap_idle, 1'b1);
      check("no_output_after_abort", out_valid, 1'b0);
    end
    @(posedge ap_clk); #1;

    fill_sorted_random();
    run_block(2, 1'b0, 1'b0);

    repeat (2) @(posedge ap_clk);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
